// File: rtl/mips_pkg.sv
// Shared constants and helpers for the register-file write-back slice.
//   DATA_W   : register data width
//   ADDR_W   : register address width (MIPS 5-bit encoding)
//   NUM_REGS : implemented registers; addresses >= NUM_REGS are out of range
//   ZERO_REG : hard-wired $zero, never written and never pending
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 16;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2
  } wb_src_e;

  function automatic logic addr_in_range(input reg_addr_t a);
    return a < reg_addr_t'(NUM_REGS);
  endfunction

  // A destination that actually lands in the register file.
  function automatic logic addr_writable(input reg_addr_t a);
    return addr_in_range(a) && (a != ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the write-back block's bus signals.
//   ALU result   : alu_valid / alu_addr / alu_data (no backpressure)
//   Load result  : mem_valid / mem_ready / mem_addr / mem_data (valid/ready)
//   Issue        : issue_valid / issue_addr (load destination being issued)
//   Hazard check : chk_reg_1 / chk_reg_2 in, stall out
//   Regfile port : write_add / write_dat / regwrite, plus addr_err pulse
// Modport slave is the write-back block; master is the pipeline around it.
interface regfile_writeback_if;
  import mips_pkg::*;

  logic      alu_valid;
  reg_addr_t alu_addr;
  reg_data_t alu_data;

  logic      mem_valid;
  logic      mem_ready;
  reg_addr_t mem_addr;
  reg_data_t mem_data;

  logic      issue_valid;
  reg_addr_t issue_addr;

  reg_addr_t chk_reg_1;
  reg_addr_t chk_reg_2;
  logic      stall;

  reg_addr_t write_add;
  reg_data_t write_dat;
  logic      regwrite;
  logic      addr_err;

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    input  issue_valid, issue_addr,
    input  chk_reg_1, chk_reg_2,
    output stall,
    output write_add, write_dat, regwrite, addr_err
  );

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    output issue_valid, issue_addr,
    output chk_reg_1, chk_reg_2,
    input  stall,
    input  write_add, write_dat, regwrite, addr_err
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per implemented register.
//   clk, rst_n    : clock, asynchronous active-low reset (clears all bits)
//   set_valid_i   : a load was issued to set_addr_i this cycle
//   clr_valid_i   : a load result to clr_addr_i is being written this cycle
//   chk_reg_1_i/2 : decode source operands to look up
//   stall_o       : either source operand has a load still outstanding
module wb_scoreboard
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_valid_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_valid_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t chk_reg_1_i,
  input  reg_addr_t chk_reg_2_i,
  output logic      stall_o
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        // $zero never waits on anything.
        assign pending_d[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        // Exact address match also rejects out-of-range addresses.
        assign set_hit = set_valid_i && (set_addr_i == reg_addr_t'(gi));
        assign clr_hit = clr_valid_i && (clr_addr_i == reg_addr_t'(gi));
        // A fresh issue outranks the completion of the older load.
        assign pending_d[gi] = set_hit | (pending_q[gi] & ~clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  logic hit_1;
  logic hit_2;

  always_comb begin
    hit_1 = 1'b0;
    hit_2 = 1'b0;
    if (addr_writable(chk_reg_1_i)) hit_1 = pending_q[chk_reg_1_i[IDX_W-1:0]];
    if (addr_writable(chk_reg_2_i)) hit_2 = pending_q[chk_reg_2_i[IDX_W-1:0]];
  end

  assign stall_o = hit_1 | hit_2;

endmodule

// File: rtl/regfile_writeback.sv
// Write-side master of the 16-entry register file.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_writeback_if.slave -- ALU and load result inputs,
//                load handshake, issue tracking, RAW hazard check and the
//                registered write port (write_add/write_dat/regwrite) with
//                the addr_err drop indication.
// ALU results always win the write port; a load is accepted only in a cycle
// without an ALU result. The chosen source is registered one cycle later.
module regfile_writeback
  import mips_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  regfile_writeback_if.slave  bus
);

  // ---------------- arbitration ----------------
  wb_src_e   src_sel;
  reg_addr_t src_addr;
  reg_data_t src_data;
  logic      mem_fire;

  assign bus.mem_ready = ~bus.alu_valid;

  always_comb begin
    src_sel  = SRC_NONE;
    src_addr = '0;
    src_data = '0;
    mem_fire = 1'b0;
    if (bus.alu_valid) begin
      src_sel  = SRC_ALU;
      src_addr = bus.alu_addr;
      src_data = bus.alu_data;
    end else if (bus.mem_valid) begin
      src_sel  = SRC_MEM;
      src_addr = bus.mem_addr;
      src_data = bus.mem_data;
      mem_fire = 1'b1;
    end
  end

  // ---------------- output register ----------------
  reg_addr_t write_add_q, write_add_d;
  reg_data_t write_dat_q, write_dat_d;
  logic      regwrite_q,  regwrite_d;
  logic      addr_err_q,  addr_err_d;

  always_comb begin
    write_add_d = write_add_q;
    write_dat_d = write_dat_q;
    regwrite_d  = 1'b0;
    addr_err_d  = 1'b0;
    if (src_sel != SRC_NONE) begin
      if (!addr_in_range(src_addr)) begin
        // Consumed but dropped; the pulse tells the pipeline about it.
        addr_err_d = 1'b1;
      end else if (src_addr != ZERO_REG) begin
        write_add_d = src_addr;
        write_dat_d = src_data;
        regwrite_d  = 1'b1;
      end
      // Writes to $zero are consumed silently and leave the port untouched.
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_add_q <= '0;
      write_dat_q <= '0;
      regwrite_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      write_add_q <= write_add_d;
      write_dat_q <= write_dat_d;
      regwrite_q  <= regwrite_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign bus.write_add = write_add_q;
  assign bus.write_dat = write_dat_q;
  assign bus.regwrite  = regwrite_q;
  assign bus.addr_err  = addr_err_q;

  // ---------------- pending-load scoreboard ----------------
  // Only accepted loads retire a pending bit; ALU writes leave it alone.
  wb_scoreboard u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_valid_i (bus.issue_valid),
    .set_addr_i  (bus.issue_addr),
    .clr_valid_i (mem_fire),
    .clr_addr_i  (bus.mem_addr),
    .chk_reg_1_i (bus.chk_reg_1),
    .chk_reg_2_i (bus.chk_reg_2),
    .stall_o     (bus.stall)
  );

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  logic clk;
  logic rst_n;

  regfile_writeback_if bus ();

  regfile_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  // Reference state: which registers await a load, and what the write port
  // should currently show.
  bit          pend [0:15];
  logic [4:0]  exp_wadd;
  logic [31:0] exp_wdat;
  bit          exp_rw;
  bit          exp_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit pend_of(input int a);
    if (a > 0 && a < 16) return pend[a];
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
    exp_wadd = '0;
    exp_wdat = '0;
    exp_rw   = 1'b0;
    exp_err  = 1'b0;
  endtask

  task automatic drive_idle();
    bus.alu_valid   = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid   = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;
    bus.issue_valid = 1'b0; bus.issue_addr = '0;
    bus.chk_reg_1   = '0;   bus.chk_reg_2 = '0;
  endtask

  task automatic check_port(input string pfx);
    check_val({pfx, "_regwrite"},  bus.regwrite,  exp_rw);
    check_val({pfx, "_addr_err"},  bus.addr_err,  exp_err);
    check_val({pfx, "_write_add"}, bus.write_add, exp_wadd);
    check_val({pfx, "_write_dat"}, bus.write_dat, exp_wdat);
  endtask

  // One clock cycle of stimulus, entered and left at a falling edge.
  task automatic step(input bit av, input int aa, input logic [31:0] ad,
                      input bit mv, input int ma, input logic [31:0] md,
                      input bit iv, input int ia, input int c1, input int c2);
    bit          have;
    int          wa;
    logic [31:0] wd;
    bit          take_mem;
    bus.alu_valid = av;   bus.alu_addr = 5'(aa);   bus.alu_data = ad;
    bus.mem_valid = mv;   bus.mem_addr = 5'(ma);   bus.mem_data = md;
    bus.issue_valid = iv; bus.issue_addr = 5'(ia);
    bus.chk_reg_1 = 5'(c1); bus.chk_reg_2 = 5'(c2);
    #1;
    check_val("mem_ready", bus.mem_ready, !av);
    check_val("stall", bus.stall, pend_of(c1) | pend_of(c2));
    // Reference: ALU first, otherwise an offered load.
    take_mem = mv && !av;
    have = 1'b0; wa = 0; wd = '0;
    if (av) begin
      have = 1'b1; wa = aa; wd = ad;
    end else if (take_mem) begin
      have = 1'b1; wa = ma; wd = md;
    end
    exp_rw  = have && wa != 0 && wa < 16;
    exp_err = have && wa >= 16;
    if (exp_rw) begin
      exp_wadd = 5'(wa);
      exp_wdat = wd;
    end
    if (take_mem && ma > 0 && ma < 16) pend[ma] = 1'b0;
    if (iv && ia > 0 && ia < 16) pend[ia] = 1'b1;
    @(posedge clk);
    #1;
    check_port("wr");
    n_txn++;
    $display("txn %0d: alu=%0b/%0d mem=%0b/%0d issue=%0b/%0d -> regwrite=%0b add=%0d dat=0x%08h err=%0b stall=%0b",
             n_txn, av, aa, mv, ma, iv, ia, bus.regwrite, bus.write_add, bus.write_dat, bus.addr_err, bus.stall);
    @(negedge clk);
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 15));
  endfunction

  bit          mem_hold;
  int          mem_a;
  logic [31:0] mem_d;

  initial begin
    model_reset();
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_port("reset");
    check_val("reset_stall", bus.stall, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU write, then an idle cycle to see the strobe drop and data hold.
    step(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Collision: ALU wins, the held load goes through the next cycle.
    step(1, 4, 32'h11, 1, 6, 32'h22, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6, 32'h22, 0, 0, 0, 0);

    // Hazard on register 7 until its load retires.
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    step(1, 7, 32'h77, 0, 0, 0, 0, 0, 0, 7);      // ALU write keeps it pending
    step(0, 0, 0, 1, 7, 32'h700, 0, 0, 0, 7);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);

    // Same-cycle retire and re-issue of register 9.
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    step(0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);

    // Boundaries: $zero, out of range, out-of-range checks.
    step(1, 0, 32'h12345678, 0, 0, 0, 1, 0, 0, 0);
    step(1, 20, 32'h55, 0, 0, 0, 1, 20, 20, 0);
    step(0, 0, 0, 1, 31, 32'h66, 0, 0, 0, 25);
    step(1, 15, 32'hF00D, 0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic with loads held until accepted.
    mem_hold = 1'b0; mem_a = 0; mem_d = '0;
    for (int n = 0; n < 400; n++) begin
      bit av;
      av = ($urandom_range(0, 2) == 0);
      if (!mem_hold && $urandom_range(0, 1) == 1) begin
        mem_hold = 1'b1;
        mem_a = rand_addr();
        mem_d = $urandom;
      end
      step(av, rand_addr(), $urandom, mem_hold, mem_a, mem_d,
           ($urandom_range(0, 2) == 0), rand_addr(), rand_addr(), rand_addr());
      if (mem_hold && !av) mem_hold = 1'b0;
    end

    // Mid-stream reset with register 5 pending and an ALU write in flight.
    step(0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
    step(1, 2, 32'hABCD, 0, 0, 0, 0, 0, 0, 0);
    bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'hCAFE;
    bus.mem_valid = 1'b0; bus.issue_valid = 1'b0;
    bus.chk_reg_1 = 5'd5; bus.chk_reg_2 = 5'd0;
    #1;
    check_val("pre_rst_stall", bus.stall, pend_of(5));
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_port("midrst");
    check_val("midrst_stall", bus.stall, 1'b0);
    @(posedge clk);
    #1;
    check_port("midrst_edge");
    check_val("midrst_edge_stall", bus.stall, 1'b0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
    step(1, 8, 32'h8888, 0, 0, 0, 0, 0, 5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
